lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random bit generator with a valid/ready output stream.
//  Emits BPC bits per transfer. Supports seed load at any time and zero-state lock-up recovery.
//  Measures the sequence period in hardware.
//  Feeds scramblers, BIST pattern sources and noise injection in the lab designs.
// PARAMETERS
//  WIDTH        8      state register width, 3..32
//  TAPS         8'h1D  feedback mask; bit i set => SR[i] enters the XOR (x^8+x^4+x^3+x^2+1)
//  BPC          1      bits emitted per transfer, 1..WIDTH
//  DEFAULT_SEED 8'h01  substitute seed used when a zero seed or a zero state occurs; must be nonzero
// PORTS
//  CLK         in   1      clock, rising edge
//  RST         in   1      synchronous reset, active-high; loads SEED
//  SEED        in   WIDTH  seed value, sampled on RST or LOAD
//  LOAD        in   1      load SEED and restart the period counter
//  EN          in   1      run enable; low freezes the state and deasserts DVALID
//  DOUT        out  BPC    next output bits; DOUT[0] is emitted first
//  DVALID      out  1      DOUT is valid
//  DREADY      in   1      consumer accepts DOUT
//  LOCKUP      out  1      sticky flag: zero seed or zero state was replaced by DEFAULT_SEED; cleared by RST/LOAD with a nonzero SEED
//  PERIOD_DONE out  1      one-cycle pulse when the state returns to the loaded seed
//  PERIOD_LEN  out  WIDTH  transfers counted up to the last PERIOD_DONE
// BEHAVIOUR
//  Reset (RST=1 at posedge):
//   - SR <= (SEED==0) ? DEFAULT_SEED : SEED; seed_reg <= the same value.
//   - LOCKUP <= (SEED==0). cnt <= 0. PERIOD_LEN <= 0. PERIOD_DONE <= 0.
//  Priority at each edge: RST > LOAD > advance.
//   - LOAD performs the same actions as RST, except PERIOD_LEN holds its value.
//  One step (right shift):
//   - fb = ^(SR & TAPS); SR' = {fb, SR[WIDTH-1:1]}; the emitted bit is SR[0].
//  Output:
//   - DOUT = SR[BPC-1:0], combinational from the state register; it equals the next BPC emitted bits in order.
//   - DVALID = EN & ~RST_cycle & ~LOAD_cycle, registered. It goes low in the cycle after RST or LOAD and returns high the next cycle.
//  Transfer:
//   - A transfer occurs when DVALID & DREADY at posedge.
//   - SR advances BPC steps in that cycle (a combinational chain of BPC steps). cnt <= cnt+1.
//   - With no transfer, SR and DOUT hold. DOUT must stay stable while DVALID & ~DREADY.
//  Lock-up:
//   - If the BPC-step result is all-zero, SR <= DEFAULT_SEED instead and LOCKUP <= 1.
//   - Lock-up cannot occur for invertible TAPS (bit 0 set) but must be handled for any TAPS.
//  Period:
//   - If the advanced state equals seed_reg, PERIOD_DONE pulses in the next cycle.
//   - At the same time PERIOD_LEN <= cnt+1 and cnt <= 0.
//   - cnt saturates at all-ones and does not wrap.
//  Simultaneous events:
//   - LOAD together with a transfer: the load wins and the transfer is not counted.
//   - The consumer must treat DOUT as discarded when this happens.
//  EN low mid-stream:
//   - State, cnt and LOCKUP hold; DVALID drops at the next edge. A transfer in the EN-fall cycle still completes.
//  SEED changes are ignored except in RST or LOAD cycles.
// STRUCTURE
//  Package lfsr_pkg:
//   - Maximal-length TAPS constants for widths 3..32, e.g. TAPS_8 = 8'h1D, TAPS_16 = 16'h002D.
//   - A nonzero DEFAULT_SEED constant.
//  Sub-module lfsr_step (combinational, WIDTH/TAPS parameters):
//   - Computes one step, state in -> state out.
//   - Instantiated BPC times in a generate chain.
//  Top level:
//   - State register, seed register, handshake, period counter, lock-up logic.
// TESTING
//  1. WIDTH=8, TAPS=8'h1D, BPC=1; RST with SEED=8'h01; DREADY=1. Required sequence:
//     - DOUT=1; then SR=8'h80, DOUT=0; then SR=8'h40.
//  2. Same configuration run continuously: PERIOD_DONE pulses after exactly 255 transfers and PERIOD_LEN=255.
//     - A second pulse follows 255 transfers later.
//  3. BPC=2, SEED=8'h01: DOUT=2'b01 and DVALID=1. One transfer gives SR=8'h40.
//     - Hold DREADY=0 for 5 cycles: SR and DOUT remain stable.
//  4. LOAD with SEED=8'h00 mid-stream:
//     - SR=DEFAULT_SEED, LOCKUP=1, DVALID low for 1 cycle, cnt=0.
//     - A subsequent LOAD with 8'h5A clears LOCKUP.
//  5. TAPS=8'h14 (non-invertible), seed 8'h01:
//     - The first transfer yields a zero result, so SR=8'h01 (reseed) and LOCKUP=1.
//  6. EN=0 for 3 cycles, then RST while DREADY=1 during a transfer:
//     - The state holds while EN=0, then resets to SEED. No PERIOD_DONE pulse occurs.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length feedback masks and the lock-up recovery seed for lfsr_stream
package lfsr_pkg;

    localparam logic [2:0]  TAPS_3  = 3'h3;
    localparam logic [3:0]  TAPS_4  = 4'h3;
    localparam logic [4:0]  TAPS_5  = 5'h05;
    localparam logic [5:0]  TAPS_6  = 6'h03;
    localparam logic [6:0]  TAPS_7  = 7'h03;
    localparam logic [7:0]  TAPS_8  = 8'h1D;
    localparam logic [8:0]  TAPS_9  = 9'h011;
    localparam logic [9:0]  TAPS_10 = 10'h009;
    localparam logic [10:0] TAPS_11 = 11'h005;
    localparam logic [11:0] TAPS_12 = 12'h053;
    localparam logic [12:0] TAPS_13 = 13'h001B;
    localparam logic [13:0] TAPS_14 = 14'h0443;
    localparam logic [14:0] TAPS_15 = 15'h0003;
    localparam logic [15:0] TAPS_16 = 16'h002D;
    localparam logic [16:0] TAPS_17 = 17'h00009;
    localparam logic [17:0] TAPS_18 = 18'h00081;
    localparam logic [18:0] TAPS_19 = 19'h00027;
    localparam logic [19:0] TAPS_20 = 20'h00009;
    localparam logic [20:0] TAPS_21 = 21'h000005;
    localparam logic [21:0] TAPS_22 = 22'h000003;
    localparam logic [22:0] TAPS_23 = 23'h000021;
    localparam logic [23:0] TAPS_24 = 24'h000087;
    localparam logic [24:0] TAPS_25 = 25'h0000009;
    localparam logic [25:0] TAPS_26 = 26'h0000047;
    localparam logic [26:0] TAPS_27 = 27'h0000027;
    localparam logic [27:0] TAPS_28 = 28'h0000009;
    localparam logic [28:0] TAPS_29 = 29'h00000005;
    localparam logic [29:0] TAPS_30 = 30'h00000053;
    localparam logic [30:0] TAPS_31 = 31'h00000009;
    localparam logic [31:0] TAPS_32 = 32'h00400007;

    // any nonzero value works; 1 keeps the restart point easy to recognise
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    // mask bit i set means state bit i joins the feedback parity
    function automatic logic [31:0] max_taps(input int w);
        case (w)
            3:  return 32'(TAPS_3);
            4:  return 32'(TAPS_4);
            5:  return 32'(TAPS_5);
            6:  return 32'(TAPS_6);
            7:  return 32'(TAPS_7);
            8:  return 32'(TAPS_8);
            9:  return 32'(TAPS_9);
            10: return 32'(TAPS_10);
            11: return 32'(TAPS_11);
            12: return 32'(TAPS_12);
            13: return 32'(TAPS_13);
            14: return 32'(TAPS_14);
            15: return 32'(TAPS_15);
            16: return 32'(TAPS_16);
            17: return 32'(TAPS_17);
            18: return 32'(TAPS_18);
            19: return 32'(TAPS_19);
            20: return 32'(TAPS_20);
            21: return 32'(TAPS_21);
            22: return 32'(TAPS_22);
            23: return 32'(TAPS_23);
            24: return 32'(TAPS_24);
            25: return 32'(TAPS_25);
            26: return 32'(TAPS_26);
            27: return 32'(TAPS_27);
            28: return 32'(TAPS_28);
            29: return 32'(TAPS_29);
            30: return 32'(TAPS_30);
            31: return 32'(TAPS_31);
            32: return TAPS_32;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one right-shift Fibonacci step, parity of the tapped bits enters at the top
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    assign state_out = {^(state_in & TAPS), state_in[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: LFSR bit source with valid/ready output, seed load, lock-up recovery and period measurement
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(max_taps(WIDTH)),
    parameter int               BPC          = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SEED,
    input  logic             LOAD,
    input  logic             EN,
    output logic [BPC-1:0]   DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             LOCKUP,
    output logic             PERIOD_DONE,
    output logic [WIDTH-1:0] PERIOD_LEN
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_sr;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] adv_val;
    logic [WIDTH-1:0] cnt_inc;
    logic             seed_zero;
    logic             zero_res;
    logic             xfer;
    logic             period_hit;
    logic             restart;

    // BPC single steps chained so a whole transfer advances in one cycle
    for (genvar i = 0; i < BPC; i++) begin : g_step
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_out;
        if (i == 0) begin : g_first
            assign s_in = sr;
        end else begin : g_next
            assign s_in = g_step[i-1].s_out;
        end
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .state_in  (s_in),
            .state_out (s_out)
        );
    end

    assign next_sr    = g_step[BPC-1].s_out;
    assign seed_zero  = SEED == '0;
    assign load_val   = seed_zero ? DEFAULT_SEED : SEED;
    assign zero_res   = next_sr == '0;
    assign adv_val    = zero_res ? DEFAULT_SEED : next_sr;
    assign xfer       = DVALID & DREADY;
    assign period_hit = adv_val == seed_reg;
    assign restart    = RST | LOAD;
    assign cnt_inc    = &cnt ? cnt : cnt + WIDTH'(1);
    assign DOUT       = sr[BPC-1:0];

    // state, seed and lock-up flag: restart loads the seed, a transfer advances and reseeds on zero
    always_ff @(posedge CLK) begin
        if (restart) begin
            sr       <= load_val;
            seed_reg <= load_val;
            LOCKUP   <= seed_zero;
        end else if (xfer) begin
            sr       <= adv_val;
            LOCKUP   <= LOCKUP | zero_res;
        end
    end

    // handshake and period measurement; a load beats a simultaneous transfer, so it is never counted
    always_ff @(posedge CLK) begin
        if (restart) begin
            DVALID      <= 1'b0;
            PERIOD_DONE <= 1'b0;
            cnt         <= '0;
            if (RST) PERIOD_LEN <= '0;
        end else begin
            DVALID      <= EN;
            PERIOD_DONE <= xfer & period_hit;
            if (xfer) cnt <= period_hit ? '0 : cnt_inc;
            if (xfer && period_hit) PERIOD_LEN <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: three lfsr_stream configurations against a bit-list reference model
module tb_lfsr_stream;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LOAD = 1'b0;
    logic       EN = 1'b1;
    logic       DREADY = 1'b1;
    logic [7:0] SEED = 8'h01;
    logic [0:0] dout0, dout2;
    logic [1:0] dout1;
    logic [2:0] dvalid, lockup, pdone;
    logic [7:0] plen [3];

    always #5 CLK = ~CLK;

    lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .BPC(1), .DEFAULT_SEED(8'h01)) u0 (
        .CLK(CLK), .RST(RST), .SEED(SEED), .LOAD(LOAD), .EN(EN), .DOUT(dout0), .DVALID(dvalid[0]),
        .DREADY(DREADY), .LOCKUP(lockup[0]), .PERIOD_DONE(pdone[0]), .PERIOD_LEN(plen[0]));
    lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .BPC(2), .DEFAULT_SEED(8'h01)) u1 (
        .CLK(CLK), .RST(RST), .SEED(SEED), .LOAD(LOAD), .EN(EN), .DOUT(dout1), .DVALID(dvalid[1]),
        .DREADY(DREADY), .LOCKUP(lockup[1]), .PERIOD_DONE(pdone[1]), .PERIOD_LEN(plen[1]));
    lfsr_stream #(.WIDTH(8), .TAPS(8'h14), .BPC(1), .DEFAULT_SEED(8'h01)) u2 (
        .CLK(CLK), .RST(RST), .SEED(SEED), .LOAD(LOAD), .EN(EN), .DOUT(dout2), .DVALID(dvalid[2]),
        .DREADY(DREADY), .LOCKUP(lockup[2]), .PERIOD_DONE(pdone[2]), .PERIOD_LEN(plen[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // reference model: m_bits[k][i] is the i-th bit still to be emitted by instance k
    int         nb [3] = '{1, 2, 1};
    logic [7:0] tp [3] = '{8'h1D, 8'h1D, 8'h14};
    logic [7:0] m_bits [3];
    logic [7:0] m_seed [3];
    bit         m_lock [3];
    bit         m_pd [3];
    int         m_cnt [3];
    int         m_plen [3];
    bit         m_dv = 1'b0;

    task automatic model_xfer(input int k);
        bit         q[$];
        logic [7:0] b;
        for (int i = 0; i < 8; i++) q.push_back(m_bits[k][i]);
        for (int n = 0; n < nb[k]; n++) begin
            bit fb = 1'b0;
            for (int i = 0; i < 8; i++) if (tp[k][i]) fb ^= q[i];
            void'(q.pop_front());
            q.push_back(fb);
        end
        for (int i = 0; i < 8; i++) b[i] = q[i];
        if (b == 8'h00) begin
            b = 8'h01;
            m_lock[k] = 1'b1;
        end
        m_bits[k] = b;
        if (b == m_seed[k]) begin
            m_pd[k]   = 1'b1;
            m_plen[k] = m_cnt[k] + 1;
            m_cnt[k]  = 0;
        end else begin
            m_cnt[k] = (m_cnt[k] == 255) ? 255 : m_cnt[k] + 1;
        end
    endtask

    task automatic compare_all();
        logic [7:0] osr [3];
        logic [7:0] ocnt [3];
        logic [1:0] od [3];
        osr[0] = u0.sr; osr[1] = u1.sr; osr[2] = u2.sr;
        ocnt[0] = u0.cnt; ocnt[1] = u1.cnt; ocnt[2] = u2.cnt;
        od[0] = {1'b0, dout0}; od[1] = dout1; od[2] = {1'b0, dout2};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d_dout", k), 32'(od[k]), 32'(m_bits[k] & ((nb[k] == 2) ? 8'h03 : 8'h01)));
            check($sformatf("u%0d_sr", k), 32'(osr[k]), 32'(m_bits[k]));
            check($sformatf("u%0d_cnt", k), 32'(ocnt[k]), 32'(m_cnt[k]));
            check($sformatf("u%0d_dvalid", k), 32'(dvalid[k]), 32'(m_dv));
            check($sformatf("u%0d_lockup", k), 32'(lockup[k]), 32'(m_lock[k]));
            check($sformatf("u%0d_pdone", k), 32'(pdone[k]), 32'(m_pd[k]));
            check($sformatf("u%0d_plen", k), 32'(plen[k]), 32'(m_plen[k]));
        end
    endtask

    task automatic tick();
        bit xfer = m_dv & DREADY;
        for (int k = 0; k < 3; k++) m_pd[k] = 1'b0;
        if (RST || LOAD) begin
            for (int k = 0; k < 3; k++) begin
                m_bits[k] = (SEED == 8'h00) ? 8'h01 : SEED;
                m_seed[k] = m_bits[k];
                m_lock[k] = SEED == 8'h00;
                m_cnt[k]  = 0;
                if (RST) m_plen[k] = 0;
            end
            m_dv = 1'b0;
        end else begin
            if (xfer) for (int k = 0; k < 3; k++) model_xfer(k);
            m_dv = EN;
        end
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    initial begin
        int         n;
        int         pulses;
        logic [7:0] hold_exp;
        // reset with seed 1, then the first emitted bits
        tick();
        check("t1_reset_dout", 32'(dout0), 32'h1);
        check("t1_reset_dvalid", 32'(dvalid[0]), 32'h0);
        RST = 1'b0;
        tick();
        check("t3_dout", 32'(dout1), 32'h1);
        check("t3_dvalid", 32'(dvalid[1]), 32'h1);
        tick();
        check("t1_sr1", 32'(u0.sr), 32'h80);
        check("t1_dout1", 32'(dout0), 32'h0);
        check("t3_sr1", 32'(u1.sr), 32'h40);
        check("t5_sr", 32'(u2.sr), 32'h01);
        check("t5_lockup", 32'(lockup[2]), 32'h1);
        tick();
        check("t1_sr2", 32'(u0.sr), 32'h40);
        check("t3_sr2", 32'(u1.sr), 32'h10);
        // stalled consumer: everything holds
        DREADY = 1'b0;
        repeat (5) begin
            tick();
            check("t3_hold_sr", 32'(u1.sr), 32'h10);
            check("t3_hold_dout", 32'(dout1), 32'h0);
        end
        // full period twice
        DREADY = 1'b1;
        RST = 1'b1;
        SEED = 8'h01;
        tick();
        RST = 1'b0;
        n = 0;
        pulses = 0;
        for (int c = 0; c < 700 && pulses < 2; c++) begin
            if (dvalid[0] && DREADY) n++;
            tick();
            if (pdone[0]) begin
                pulses++;
                check("t2_xfers", 32'(n), 32'd255);
                check("t2_plen", 32'(plen[0]), 32'd255);
                n = 0;
            end
        end
        check("t2_pulses", 32'(pulses), 32'd2);
        // zero-seed load mid-stream, then a clean load
        repeat (7) tick();
        LOAD = 1'b1;
        SEED = 8'h00;
        tick();
        LOAD = 1'b0;
        check("t4_sr", 32'(u0.sr), 32'h01);
        check("t4_lockup", 32'(lockup[0]), 32'h1);
        check("t4_dvalid", 32'(dvalid[0]), 32'h0);
        check("t4_cnt", 32'(u0.cnt), 32'h0);
        check("t4_plen_kept", 32'(plen[0]), 32'd255);
        tick();
        check("t4_dvalid_back", 32'(dvalid[0]), 32'h1);
        LOAD = 1'b1;
        SEED = 8'h5A;
        tick();
        LOAD = 1'b0;
        check("t4_lockup_clr", 32'(lockup[0]), 32'h0);
        check("t4_sr_5a", 32'(u0.sr), 32'h5A);
        repeat (4) tick();
        // EN falls: the transfer in that cycle completes, then the state freezes
        EN = 1'b0;
        tick();
        hold_exp = m_bits[0];
        repeat (3) begin
            tick();
            check("t6_hold", 32'(u0.sr), 32'(hold_exp));
            check("t6_dvalid", 32'(dvalid[0]), 32'h0);
        end
        EN = 1'b1;
        repeat (2) tick();
        RST = 1'b1;
        SEED = 8'hC3;
        tick();
        RST = 1'b0;
        check("t6_sr", 32'(u0.sr), 32'hC3);
        check("t6_pdone", 32'(pdone[0]), 32'h0);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            DREADY = $urandom_range(0, 3) != 0;
            EN     = $urandom_range(0, 15) != 0;
            LOAD   = $urandom_range(0, 299) == 0;
            RST    = $urandom_range(0, 999) == 0;
            SEED   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
